// File: rtl/ps2_dev_tx_fifo.sv
// PS/2 device-side transmitter: queues scan-code bytes and sends each as an 11-bit frame.
// Latency: IDLE->LOAD->SHIFT takes 2 cycles after a byte is queued; a frame lasts 22*HALF cycles.
// Backpressure: o_ready drops when the FIFO is full; host inhibit aborts and retries the head byte.
module ps2_dev_tx_fifo #(
  parameter int DIVISOR    = 5000,
  parameter int DEPTH      = 4,
  parameter int GAP_HALVES = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [7:0]                 i_data,
  input  logic                       i_perr,
  output logic                       o_ready,
  input  logic                       i_inhibit,
  output logic                       o_ps2_clk,
  output logic                       o_ps2_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_abort,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int HALF    = DIVISOR / 2;
  localparam int CW      = $clog2(HALF) + 1;
  localparam int PW      = $clog2(DEPTH);
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int GAP_CYC = GAP_HALVES * HALF;
  localparam int GW      = $clog2(GAP_CYC) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  // FIFO storage: {perr, data} per entry
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;
  logic [8:0]    head;
  logic          head_par;

  // FSM state
  state_t        state;
  logic [CW-1:0] half_cnt;
  logic          low_ph;
  logic [3:0]    bit_k;
  logic [9:0]    frame_sr;   // bits k=1..10 still to be sent, LSB next
  logic [GW-1:0] gap_cnt;
  logic          half_end;
  logic          abort_now;

  // Ready comes from registered occupancy, so a push at full is dropped even if a pop coincides
  assign o_ready  = (count != LW'(DEPTH));
  assign push     = i_valid & o_ready;
  assign o_level  = count;
  assign o_busy   = (state != IDLE);

  assign head     = mem[rd_ptr];
  // Odd parity over the data byte, flipped when the entry was tagged for error injection
  assign head_par = ~(^head[7:0]) ^ head[8];

  assign half_end  = (half_cnt == CW'(HALF - 1));
  // Head is released only once the stop bit's low phase has fully elapsed
  assign pop       = (state == SHIFT) && low_ph && half_end && (bit_k == 4'd10);
  // Inhibit during the stop bit is ignored; earlier it kills the frame
  assign abort_now = (state == SHIFT) && i_inhibit && (bit_k != 4'd10);

  // FIFO payload write; contents need no reset since occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_perr, i_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer with registered line and pulse outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      half_cnt   <= '0;
      low_ph     <= 1'b0;
      bit_k      <= '0;
      frame_sr   <= '1;
      gap_cnt    <= '0;
      o_ps2_clk  <= 1'b1;
      o_ps2_data <= 1'b1;
      o_done     <= 1'b0;
      o_abort    <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          o_ps2_clk  <= 1'b1;
          o_ps2_data <= 1'b1;
          if (count != '0 && !i_inhibit) state <= LOAD;
        end
        LOAD: begin
          // Start bit goes straight onto the line; the rest waits in the shifter
          frame_sr   <= {1'b1, head_par, head[7:0]};
          o_ps2_clk  <= 1'b1;
          o_ps2_data <= 1'b0;
          half_cnt   <= '0;
          low_ph     <= 1'b0;
          bit_k      <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (abort_now) begin
            o_ps2_clk  <= 1'b1;
            o_ps2_data <= 1'b1;
            o_abort    <= 1'b1;
            gap_cnt    <= '0;
            state      <= GAP;
          end else if (!half_end) begin
            half_cnt <= half_cnt + CW'(1);
          end else begin
            half_cnt <= '0;
            if (!low_ph) begin
              low_ph    <= 1'b1;
              o_ps2_clk <= 1'b0;
            end else if (bit_k == 4'd10) begin
              o_ps2_clk  <= 1'b1;
              o_ps2_data <= 1'b1;
              o_done     <= 1'b1;
              gap_cnt    <= '0;
              state      <= GAP;
            end else begin
              // Data only changes at the start of a high phase
              low_ph     <= 1'b0;
              o_ps2_clk  <= 1'b1;
              o_ps2_data <= frame_sr[0];
              frame_sr   <= {1'b1, frame_sr[9:1]};
              bit_k      <= bit_k + 4'd1;
            end
          end
        end
        GAP: begin
          o_ps2_clk  <= 1'b1;
          o_ps2_data <= 1'b1;
          // Gap must be uninterrupted: any inhibit restarts the count
          if (i_inhibit)                           gap_cnt <= '0;
          else if (gap_cnt == GW'(GAP_CYC - 1))    state   <= IDLE;
          else                                     gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx_fifo.sv
module tb_ps2_dev_tx_fifo;

  localparam int DIVISOR    = 8;
  localparam int DEPTH      = 4;
  localparam int GAP_HALVES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  logic       perr;
  logic       ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       done;
  logic       abort;
  logic [2:0] level;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected 11-bit frames, bit k at position k
  logic [10:0] exp_q[$];
  int done_cnt  = 0;
  int abort_cnt = 0;

  ps2_dev_tx_fifo #(.DIVISOR(DIVISOR), .DEPTH(DEPTH), .GAP_HALVES(GAP_HALVES)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_data    (data),
    .i_perr    (perr),
    .o_ready   (ready),
    .i_inhibit (inhibit),
    .o_ps2_clk (ps2_clk),
    .o_ps2_data(ps2_data),
    .o_busy    (busy),
    .o_done    (done),
    .o_abort   (abort),
    .o_level   (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: assembles frames from data sampled on each PS/2 clock fall
  int          cyc = 0;
  logic        prev_clk = 1'b1;
  logic        in_frame = 1'b0;
  logic        after_done = 1'b0;
  int          start_cyc = 0;
  int          nb = 0;
  int          idle_cnt = 0;
  logic [10:0] got = '0;
  logic [10:0] want;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame   = 1'b0;
      after_done = 1'b0;
      nb         = 0;
      prev_clk   = 1'b1;
    end else begin
      if (!in_frame && ps2_clk && !ps2_data) begin
        in_frame  = 1'b1;
        start_cyc = cyc;
        nb        = 0;
        got       = '0;
        if (after_done) check("inter_frame_gap_ge8", 32'(idle_cnt >= 8), 1);
        after_done = 1'b0;
      end
      if (prev_clk && !ps2_clk) begin
        if (nb < 11) got[nb] = ps2_data;
        nb++;
      end
      if (done) begin
        done_cnt++;
        check("abort_with_done", 32'(abort), 0);
        check("bits_per_frame", nb, 11);
        check("done_latency", cyc - start_cyc, 88);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 0, 1);
        end else begin
          want = exp_q.pop_front();
          check("frame_bits", 32'(got), 32'(want));
        end
        in_frame   = 1'b0;
        after_done = 1'b1;
        idle_cnt   = 0;
      end else if (after_done && ps2_clk && ps2_data) begin
        idle_cnt++;
      end
      if (abort) begin
        abort_cnt++;
        in_frame = 1'b0;
        nb       = 0;
      end
      prev_clk = ps2_clk;
    end
  end

  // All stimulus tasks are entered and left on a falling system-clock edge
  task automatic push_byte(input logic [7:0] d, input logic p);
    valid = 1'b1;
    data  = d;
    perr  = p;
    @(negedge clk);
    valid = 1'b0;
    perr  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    while (c < maxc) begin
      @(negedge clk);
      if (done) break;
      c++;
    end
    if (c >= maxc) check(name, 0, 1);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int c = 0;
    while (busy && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) check(name, 0, 1);
  endtask

  task automatic wait_falls(input string name, input int n, input int maxc);
    int   seen = 0;
    logic prv  = ps2_clk;
    for (int c = 0; c < maxc && seen < n; c++) begin
      @(negedge clk);
      if (prv && !ps2_clk) seen++;
      prv = ps2_clk;
    end
    if (seen < n) check(name, seen, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int falls;
    logic prv;
    int c;

    rst_n   = 1'b0;
    valid   = 1'b0;
    data    = 8'h00;
    perr    = 1'b0;
    inhibit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", 32'(ps2_clk), 1);
    check("rst_ps2_data", 32'(ps2_data), 1);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_abort", 32'({done, abort}), 0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1
    exp_q.push_back(11'h438);
    push_byte(8'h1C, 1'b0);
    check("level_after_push", 32'(level), 1);
    wait_done("timeout_1c", 300);
    check("level_after_done", 32'(level), 0);
    wait_idle("timeout_idle1", 100);

    // Parity injection on 0xF0, then normal 0xFF
    exp_q.push_back(11'h5E0);
    exp_q.push_back(11'h7FE);
    push_byte(8'hF0, 1'b1);
    push_byte(8'hFF, 1'b0);
    wait_done("timeout_f0", 300);
    wait_done("timeout_ff", 300);
    wait_idle("timeout_idle2", 100);

    // Five back-to-back pushes into a 4-deep FIFO
    exp_q.push_back(11'h402);
    exp_q.push_back(11'h404);
    exp_q.push_back(11'h606);
    exp_q.push_back(11'h408);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        check("full_ready_low", 32'(ready), 0);
        check("full_level", 32'(level), 4);
      end
      valid = 1'b1;
      data  = 8'(i + 1);
      @(negedge clk);
    end
    valid = 1'b0;
    check("level_after_5th", 32'(level), 4);
    for (int i = 0; i < 4; i++) wait_done("timeout_burst", 300);
    wait_idle("timeout_idle3", 100);

    // Inhibit during bit k=4 of 0xAA, then retry
    exp_q.push_back(11'h754);
    push_byte(8'hAA, 1'b0);
    wait_falls("timeout_aa_falls", 4, 200);
    repeat (5) @(negedge clk);
    inhibit = 1'b1;
    c = 0;
    while (!abort && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("abort_seen", 32'(abort), 1);
    check("abort_lines_high", 32'({ps2_clk, ps2_data}), 3);
    check("abort_level_kept", 32'(level), 1);
    repeat (20) @(negedge clk);
    check("inhibit_lines_high", 32'({ps2_clk, ps2_data}), 3);
    inhibit = 1'b0;
    wait_done("timeout_aa_retry", 300);
    check("aa_level_after", 32'(level), 0);
    wait_idle("timeout_idle4", 100);

    // Inhibit during the stop bit is ignored
    exp_q.push_back(11'h6AA);
    push_byte(8'h55, 1'b0);
    wait_falls("timeout_55_falls", 10, 300);
    repeat (5) @(negedge clk);
    inhibit = 1'b1;
    wait_done("timeout_55_done", 50);
    check("stop_inhibit_no_abort", abort_cnt, 1);
    inhibit = 1'b0;
    wait_idle("timeout_idle5", 100);

    // Reset mid-frame with three bytes queued
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    wait_falls("timeout_rst_falls", 2, 200);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_lines_high", 32'({ps2_clk, ps2_data}), 3);
    check("midrst_level", 32'(level), 0);
    check("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    falls = 0;
    prv   = ps2_clk;
    repeat (60) begin
      @(negedge clk);
      if (prv && !ps2_clk) falls++;
      prv = ps2_clk;
    end
    check("no_clk_after_reset", falls, 0);

    // Fresh traffic after reset
    exp_q.push_back(11'h438);
    push_byte(8'h1C, 1'b0);
    wait_done("timeout_post_rst", 300);
    wait_idle("timeout_idle6", 100);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_done", done_cnt, 10);
    check("total_abort", abort_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
